// File: rtl/tx_ffe_prl.sv
// tx_ffe_prl: transmit feed-forward equalizer.
// Applies a signed FIR with pre/main/post cursor taps to a PAM-4 voltage stream.
// The pipeline has three stages: capture, multiply, then sum/round/clip.
// Coefficients are written to a shadow bank and copied to the active bank on commit.
// Optional feature: define TX_FFE_SAT_COUNT_EN to add the 16-bit saturating clip counter
// and its sat_count output port.
module tx_ffe_prl #(
    parameter int SIGNAL_RESOLUTION = 10,
    parameter int SYMBOL_SEPERATION = 56,
    parameter int NUM_TAPS          = 3,
    parameter int MAIN_CURSOR       = 1,
    parameter int COEF_WIDTH        = 8,
    parameter int COEF_FRAC         = 6,
    localparam int AW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic signed [SIGNAL_RESOLUTION-1:0] signal_in,
    input  logic                                signal_in_valid,
    input  logic                                coef_wr_en,
    input  logic        [AW-1:0]                coef_wr_addr,
    input  logic signed [COEF_WIDTH-1:0]        coef_wr_data,
    input  logic                                coef_commit,
    output logic signed [SIGNAL_RESOLUTION-1:0] signal_out,
    output logic                                signal_out_valid,
    output logic                                sat_flag
`ifdef TX_FFE_SAT_COUNT_EN
    ,
    output logic        [15:0]                  sat_count
`endif
);

    localparam int SR = SIGNAL_RESOLUTION;
    localparam int CW = COEF_WIDTH;
    localparam int PW = SR + CW;                 // full product width
    localparam int SW = PW + $clog2(NUM_TAPS);   // sum width with guard bits

    localparam logic signed [CW-1:0] CoefOne = CW'(1 << COEF_FRAC);
    localparam logic signed [SW-1:0] RndHalf = SW'(1 << (COEF_FRAC - 1));
    localparam logic signed [SW-1:0] OutMax  = SW'((2 ** (SR - 1)) - 1);
    localparam logic signed [SW-1:0] OutMin  = SW'(-(2 ** (SR - 1)));

    // Reject configurations that the datapath is not sized for.
    if (NUM_TAPS < 2 || NUM_TAPS > 8 || MAIN_CURSOR < 0 || MAIN_CURSOR >= NUM_TAPS ||
        COEF_FRAC < 1 || COEF_FRAC > CW - 2 || SYMBOL_SEPERATION <= 0) begin : g_bad_cfg
        $error("tx_ffe_prl: illegal parameter combination");
    end

    logic signed [SR-1:0] hist_q   [NUM_TAPS];
    logic signed [CW-1:0] shadow_q [NUM_TAPS];
    logic signed [CW-1:0] shadow_d [NUM_TAPS];
    logic signed [CW-1:0] active_q [NUM_TAPS];
    logic signed [CW-1:0] active_d [NUM_TAPS];
    logic signed [PW-1:0] prod_q   [NUM_TAPS];
    logic signed [PW-1:0] prod_d   [NUM_TAPS];
    logic [NUM_TAPS-1:0]  wr_hit;
    logic                 v1_q, v2_q;

    logic signed [SW-1:0] sum_d, rnd_d, shr_d;
    logic signed [SR-1:0] out_d;
    logic                 clip_d;

    // Coefficient bank update: writes land in shadow, commit copies with write-through.
    always_comb begin
        wr_hit = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            // Out-of-range addresses match no tap and are dropped.
            wr_hit[k]   = coef_wr_en && (int'(coef_wr_addr) == k);
            shadow_d[k] = wr_hit[k] ? coef_wr_data : shadow_q[k];
            active_d[k] = coef_commit ? shadow_d[k] : active_q[k];
        end
    end

    // Coefficient banks; reset restores identity taps.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            if (rst) begin
                shadow_q[k] <= (k == MAIN_CURSOR) ? CoefOne : '0;
                active_q[k] <= (k == MAIN_CURSOR) ? CoefOne : '0;
            end else begin
                shadow_q[k] <= shadow_d[k];
                active_q[k] <= active_d[k];
            end
        end
    end

    // S1: sample history shifts only on valid input, so idle cycles leave no zeros behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_TAPS; k++) hist_q[k] <= '0;
            v1_q <= 1'b0;
        end else begin
            if (signal_in_valid) begin
                for (int k = NUM_TAPS - 1; k > 0; k--) hist_q[k] <= hist_q[k - 1];
                hist_q[0] <= signal_in;
            end
            v1_q <= signal_in_valid;
        end
    end

    // S2 products at full precision.
    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            prod_d[k] = PW'(hist_q[k]) * PW'(active_q[k]);
        end
    end

    // S2: product registers and valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_TAPS; k++) prod_q[k] <= '0;
            v2_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_TAPS; k++) prod_q[k] <= prod_d[k];
            v2_q <= v1_q;
        end
    end

    // S3 datapath: guarded sum, round half up, arithmetic shift, clip to output range.
    always_comb begin
        sum_d = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            sum_d = sum_d + SW'(prod_q[k]);
        end
        rnd_d = sum_d + RndHalf;
        shr_d = rnd_d >>> COEF_FRAC;
        if (shr_d > OutMax) begin
            out_d  = SR'(OutMax);
            clip_d = 1'b1;
        end else if (shr_d < OutMin) begin
            out_d  = SR'(OutMin);
            clip_d = 1'b1;
        end else begin
            out_d  = SR'(shr_d);
            clip_d = 1'b0;
        end
    end

    // S3: output registers hold their value between valid outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            signal_out       <= '0;
            sat_flag         <= 1'b0;
            signal_out_valid <= 1'b0;
        end else begin
            if (v2_q) begin
                signal_out <= out_d;
                sat_flag   <= clip_d;
            end
            signal_out_valid <= v2_q;
        end
    end

`ifdef TX_FFE_SAT_COUNT_EN
    // Clip counter advances together with each clipped output and sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_count <= '0;
        end else if (v2_q && clip_d && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end
`endif

endmodule
